// File: rtl/counter_pkg.sv
// Shared types for the programmable counter tiles: count modes, FSM states
// and count-direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // The reserved encoding 3 counts exactly like WRAP.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_SAT;
            2'd2:    return MODE_ONESHOT;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: one tick every PRESCALE cycles while active.
// Only built into prog_updown_counter when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic clr,
    output logic tick
);

    // A divide-by-1 still needs one flop so the vector is never zero-width.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = active && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || !active || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with WRAP / SAT / ONESHOT modes, compare
// flag and terminal-count pulse. COUNTER_PRESCALE_EN adds a tick prescaler.
module prog_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_match,
    output logic             running,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    state_t           state;
    mode_t            eff_mode;
    logic             tick;
    logic             step;
    logic             at_bound;
    logic             hit_bound;
    logic [WIDTH-1:0] boundary;
    logic [WIDTH-1:0] next_count;
    logic             next_tc;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .active (state == ST_RUN && en),
        .clr    (clear || load),
        .tick   (tick)
    );
`else
    localparam int unused_prescale = PRESCALE;
    assign tick = 1'b1;
`endif

    assign running   = (state == ST_RUN);
    assign state_dbg = state;

    always_comb begin
        eff_mode   = decode_mode(mode);
        boundary   = (dir == DIR_UP) ? MAX_C : '0;
        at_bound   = (count == boundary);
        step       = (state == ST_RUN) && en && tick && !load && !clear;
        next_count = count;
        next_tc    = 1'b0;
        if (clear) begin
            next_count = '0;
        end else if (load) begin
            next_count = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (step) begin
            if (at_bound) begin
                if (eff_mode == MODE_WRAP) begin
                    next_count = (dir == DIR_UP) ? '0 : MAX_C;
                end
            end else begin
                next_count = (dir == DIR_DOWN) ? count - WIDTH'(1) : count + WIDTH'(1);
            end
        end
        hit_bound = step && (next_count == boundary);
        // WRAP flags the wrap itself; SAT/ONESHOT flag the arrival only.
        if (eff_mode == MODE_WRAP) begin
            next_tc = step && at_bound;
        end else begin
            next_tc = hit_bound && !at_bound;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            tc        <= 1'b0;
            cmp_match <= 1'b0;
        end else begin
            count     <= next_count;
            tc        <= next_tc;
            cmp_match <= (next_count == cmp_val);
            if (clear) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (en) state <= ST_RUN;
                    ST_RUN: begin
                        if (!en) begin
                            state <= ST_IDLE;
                        end else if (eff_mode == MODE_ONESHOT && hit_bound) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (load || (eff_mode != MODE_ONESHOT && en)) begin
                            state <= ST_RUN;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed bench for prog_updown_counter (WIDTH=8, MAX_VAL=9): a vector
// table for the single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_prog_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       dir = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [7:0] cmp_val = 8'd5;
    logic [7:0] count;
    logic       tc;
    logic       cmp_match;
    logic       running;
    state_t     state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic       dir;
        logic [1:0] mode;
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] exp_count;
        logic       exp_tc;
        logic       exp_run;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];

    prog_updown_counter #(
        .WIDTH(8),
        .MAX_VAL(9),
        .PRESCALE(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .dir       (dir),
        .mode      (mode),
        .cmp_val   (cmp_val),
        .count     (count),
        .tc        (tc),
        .cmp_match (cmp_match),
        .running   (running),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic d, input logic [1:0] m,
                         input logic c, input logic l, input logic [7:0] lv);
        en = e; dir = d; mode = m; clear = c; load = l; load_val = lv;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic e, input logic d, input logic [1:0] m,
                                input logic c, input logic l, input logic [7:0] lv,
                                input logic [7:0] cnt, input logic t, input logic r);
        vec_t v;
        v.en = e; v.dir = d; v.mode = m; v.clr = c; v.ld = l; v.lv = lv;
        v.exp_count = cnt; v.exp_tc = t; v.exp_run = r;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] exp_c;
        cycle();
        cycle();
        reset = 1'b0;
        check("reset_count", int'(count), 0);
        check("reset_tc", int'(tc), 0);
        check("reset_match", int'(cmp_match), 0);
        check("reset_running", int'(running), 0);
        check("reset_state", int'(state_dbg), int'(ST_IDLE));

`ifndef COUNTER_PRESCALE_EN
        // WRAP up 0..9 then wrap to 0 with one tc pulse
        add(1, 1, 2'd0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) add(1, 1, 2'd0, 0, 0, 0, 8'(i), 0, 1);
        add(1, 1, 2'd0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 2'd0, 0, 0, 0, 1, 0, 1);
        add(1, 1, 2'd0, 1, 0, 0, 0, 0, 0);
        // SAT down from 2, hold at 0, then resume upward
        add(0, 0, 2'd1, 0, 1, 2, 2, 0, 0);
        add(1, 0, 2'd1, 0, 0, 0, 2, 0, 1);
        add(1, 0, 2'd1, 0, 0, 0, 1, 0, 1);
        add(1, 0, 2'd1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 2'd1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 2'd1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 2'd1, 0, 0, 0, 1, 0, 1);
        add(1, 1, 2'd1, 0, 0, 0, 2, 0, 1);
        // ONESHOT up from 7 to DONE, then reload 3
        add(1, 1, 2'd2, 0, 1, 7, 7, 0, 1);
        add(1, 1, 2'd2, 0, 0, 0, 8, 0, 1);
        add(1, 1, 2'd2, 0, 0, 0, 9, 1, 0);
        add(1, 1, 2'd2, 0, 0, 0, 9, 0, 0);
        add(1, 1, 2'd2, 0, 1, 3, 3, 0, 1);
        add(1, 1, 2'd2, 0, 0, 0, 4, 0, 1);
        add(1, 1, 2'd2, 0, 0, 0, 5, 0, 1);
        // load clamp, load+clear, WRAP down, reserved mode
        add(0, 1, 2'd0, 0, 1, 200, 9, 0, 0);
        add(1, 1, 2'd0, 0, 0, 0, 9, 0, 1);
        add(1, 1, 2'd0, 1, 1, 4, 0, 0, 0);
        add(1, 1, 2'd0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 2'd0, 0, 0, 0, 9, 1, 1);
        add(1, 0, 2'd0, 0, 0, 0, 8, 0, 1);
        add(1, 1, 2'd3, 0, 1, 9, 9, 0, 1);
        add(1, 1, 2'd3, 0, 0, 0, 0, 1, 1);
        add(1, 1, 2'd3, 0, 0, 0, 1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].clr, vecs[i].ld, vecs[i].lv);
            cycle();
            check($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].exp_count));
            check($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
            check($sformatf("vec%0d_match", i), int'(cmp_match), int'(vecs[i].exp_count == 8'd5));
            check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_run));
        end

        // Leaving ONESHOT while in DONE with en held resumes RUN
        drive(0, 1, 2'd2, 1, 0, 0); cycle();
        drive(0, 1, 2'd2, 0, 1, 8); cycle();
        drive(1, 1, 2'd2, 0, 0, 0); cycle();
        check("done_pre_count", int'(count), 8);
        cycle();
        check("done_state", int'(state_dbg), int'(ST_DONE));
        check("done_tc", int'(tc), 1);
        check("done_running", int'(running), 0);
        drive(1, 1, 2'd0, 0, 0, 0); cycle();
        check("done_exit_running", int'(running), 1);
        check("done_exit_count", int'(count), 9);
        cycle();
        check("done_exit_wrap", int'(count), 0);
        check("done_exit_tc", int'(tc), 1);

        // Count up to 6 with cmp_val=6, then assert reset between edges
        cmp_val = 8'd6;
        drive(0, 1, 2'd0, 1, 0, 0); cycle();
        drive(1, 1, 2'd0, 0, 0, 0);
        exp_q.push_back(8'd0);
        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
        while (exp_q.size() > 0) begin
            cycle();
            exp_c = exp_q.pop_front();
            check("ramp_count", int'(count), int'(exp_c));
        end
        check("ramp_match_at_6", int'(cmp_match), 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_count", int'(count), 0);
        check("async_reset_match", int'(cmp_match), 0);
        check("async_reset_tc", int'(tc), 0);
        check("async_reset_running", int'(running), 0);
        check("async_reset_state", int'(state_dbg), int'(ST_IDLE));
        cycle();
        reset = 1'b0;
`else
        // Prescale 4: first step 5 edges after en; en drop restarts the divider
        begin
            logic [7:0] pexp[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3};
            for (int i = 0; i < 16; i++) begin
                drive((i == 10) ? 1'b0 : 1'b1, 1, 2'd0, 0, 0, 0);
                cycle();
                check($sformatf("presc_edge%0d_count", i + 1), int'(count), int'(pexp[i]));
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
